// File: rtl/seq_arith_unit_if.sv
// Request/response bundle for seq_arith_unit.
//   start  : request, sampled only while busy is low
//   op     : 00 add, 01 sub, 10 mul, 11 div
//   a, b   : unsigned operands, WIDTH bits
//   busy   : operation in progress (high in CALC and DONE)
//   done   : one-cycle pulse, result/flag valid
//   result : registered 2*WIDTH-bit result
//   flag   : add carry / sub borrow / mul 0 / div divide-by-zero
// master = issuing controller, slave = arithmetic unit.
interface seq_arith_unit_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [1:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   flag;

    modport master (
        output start, op, a, b,
        input  busy, done, result, flag
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, flag
    );
endinterface

// File: rtl/seq_arith_unit.sv
// Multi-cycle unsigned arithmetic unit: add, sub, shift-add multiply and
// restoring divide, one operation at a time behind a start/busy/done handshake.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_arith_unit_if.slave (start, op, a, b in; busy, done, result, flag out)
// Latency from accept: 1 CALC edge for add/sub, WIDTH CALC edges for mul/div,
// plus one DONE cycle. WIDTH must be at least 2.
module seq_arith_unit #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    seq_arith_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   result_q;
    logic                 flag_q;

    logic                 last_step;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 flag_step;

    // Add/sub datapath (single step)
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;

    // Shift-add multiply: acc = {partial product high half, remaining multiplier bits}
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    // Restoring divide: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]       div_trial;
    logic                 div_fits;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;

    assign last_step = (cnt == CW'(1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_CALC;
            ST_CALC: if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath step ----------------
    always_comb begin
        add_sum   = {1'b0, a_q} + {1'b0, b_q};
        sub_diff  = {1'b0, a_q} - {1'b0, b_q};

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        // With b=0 every trial fits, so the quotient fills with ones and the
        // remainder simply collects the dividend bits, ending equal to a.
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_fits  = (div_trial >= {1'b0, b_q});
        div_rem   = div_fits ? (div_trial[WIDTH-1:0] - b_q) : div_trial[WIDTH-1:0];
        div_next  = {div_rem, acc[WIDTH-2:0], div_fits};

        acc_step  = '0;
        flag_step = 1'b0;
        case (op_q)
            OP_ADD: begin
                acc_step  = {{(WIDTH-1){1'b0}}, add_sum};
                flag_step = add_sum[WIDTH];
            end
            OP_SUB: begin
                acc_step  = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                flag_step = sub_diff[WIDTH];
            end
            OP_MUL: begin
                acc_step  = mul_next;
                flag_step = 1'b0;
            end
            default: begin
                acc_step  = div_next;
                flag_step = (b_q == '0);
            end
        endcase
    end

    // ---------------- operand capture, iteration, result ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        a_q  <= bus.a;
                        b_q  <= bus.b;
                        // mul starts from the multiplier, div from the dividend
                        acc  <= bus.op[0] ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{1'b0}}, bus.b};
                        cnt  <= bus.op[1] ? CW'(WIDTH) : CW'(1);
                    end
                end
                ST_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                    // result only changes on the edge entering DONE
                    if (last_step) begin
                        result_q <= acc_step;
                        flag_q   <= flag_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;
    assign bus.flag   = flag_q;
endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed and swept checks of seq_arith_unit at WIDTH=4 and WIDTH=8.
module tb_seq_arith_unit;
    logic clk;
    logic reset_n;
    int   n_run;
    int   n_fail;

    seq_arith_unit_if #(.WIDTH(4)) if4 ();
    seq_arith_unit_if #(.WIDTH(8)) if8 ();

    seq_arith_unit #(.WIDTH(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));
    seq_arith_unit #(.WIDTH(8)) u8 (.clk(clk), .reset_n(reset_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: returns {flag, result[15:0]}
    function automatic logic [16:0] model(input int w, input logic [1:0] o, input int x, input int y);
        int mask;
        int r;
        logic f;
        mask = (1 << w) - 1;
        case (o)
            2'd0: begin r = x + y; f = ((x + y) > mask); end
            2'd1: begin r = (x - y) & mask; f = (x < y); end
            2'd2: begin r = x * y; f = 1'b0; end
            default: begin
                if (y == 0) begin r = (x << w) | mask; f = 1'b1; end
                else begin r = ((x % y) << w) | (x / y); f = 1'b0; end
            end
        endcase
        return {f, 16'(r)};
    endfunction

    // Issues one op on the WIDTH=4 unit and reports what was observed.
    // lat = edges from accept to done (99 if done never came).
    task automatic do_op4(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                          output logic [7:0] res, output logic flg, output int lat,
                          output logic busy_acc, output logic busy_end,
                          output logic done_end, output logic held);
        logic [7:0] prev;
        @(negedge clk);
        if4.op = o; if4.a = x; if4.b = y; if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        busy_acc = if4.busy;
        prev = if4.result;
        held = 1'b1;
        // scramble inputs: captured operands must be used
        if4.op = ~o; if4.a = ~x; if4.b = ~y;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!if4.done && if4.result !== prev) held = 1'b0;
        end while (!if4.done && lat < 40);
        if (!if4.done) lat = 99;
        res = if4.result;
        flg = if4.flag;
        @(posedge clk); #1;
        busy_end = if4.busy;
        done_end = if4.done;
    endtask

    task automatic do_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] res, output logic flg, output int lat);
        @(negedge clk);
        if8.op = o; if8.a = x; if8.b = y; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        if8.a = ~x; if8.b = ~y;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if8.done && lat < 40);
        if (!if8.done) lat = 99;
        res = if8.result;
        flg = if8.flag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_run++; if (if4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", if4.busy); end
        n_run++; if (if4.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", if4.done); end
        n_run++; if (if4.result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h expected 00", if4.result); end
        n_run++; if (if4.flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b expected 0", if4.flag); end
        n_run++; if (if8.result !== 16'h0000 || if8.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_w8: got result %h busy %b expected 0000 0", if8.result, if8.busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        logic [7:0] res; logic flg, ba, be, de, hd; int lat;
        do_op4(2'b00, 4'b1111, 4'b0001, res, flg, lat, ba, be, de, hd);
        n_run++; if (res !== 8'h10) begin n_fail++; $display("FAIL add_result: got %h expected 10", res); end
        n_run++; if (flg !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b expected 1", flg); end
        n_run++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_run++; if (ba !== 1'b1) begin n_fail++; $display("FAIL add_busy_after_accept: got %b expected 1", ba); end
        n_run++; if (be !== 1'b0) begin n_fail++; $display("FAIL add_busy_after_done: got %b expected 0", be); end
        n_run++; if (de !== 1'b0) begin n_fail++; $display("FAIL add_done_width: got %b expected 0", de); end
    endtask

    task automatic test_sub();
        logic [7:0] res; logic flg, ba, be, de, hd; int lat;
        do_op4(2'b01, 4'b0011, 4'b0101, res, flg, lat, ba, be, de, hd);
        n_run++; if (res !== 8'h0E) begin n_fail++; $display("FAIL sub_borrow_result: got %h expected 0e", res); end
        n_run++; if (flg !== 1'b1) begin n_fail++; $display("FAIL sub_borrow_flag: got %b expected 1", flg); end
        n_run++; if (lat !== 1) begin n_fail++; $display("FAIL sub_latency: got %0d expected 1", lat); end
        do_op4(2'b01, 4'b0101, 4'b0011, res, flg, lat, ba, be, de, hd);
        n_run++; if (res !== 8'h02) begin n_fail++; $display("FAIL sub_result: got %h expected 02", res); end
        n_run++; if (flg !== 1'b0) begin n_fail++; $display("FAIL sub_flag: got %b expected 0", flg); end
    endtask

    task automatic test_mul();
        logic [7:0] res; logic flg, ba, be, de, hd; int lat;
        do_op4(2'b10, 4'b1111, 4'b1111, res, flg, lat, ba, be, de, hd);
        n_run++; if (res !== 8'hE1) begin n_fail++; $display("FAIL mul_result: got %h expected e1", res); end
        n_run++; if (flg !== 1'b0) begin n_fail++; $display("FAIL mul_flag: got %b expected 0", flg); end
        n_run++; if (lat !== 4) begin n_fail++; $display("FAIL mul_latency: got %0d expected 4", lat); end
        n_run++; if (hd !== 1'b1) begin n_fail++; $display("FAIL mul_result_held: got %b expected 1", hd); end
        n_run++; if (be !== 1'b0) begin n_fail++; $display("FAIL mul_busy_after_done: got %b expected 0", be); end
        do_op4(2'b10, 4'b1010, 4'b0000, res, flg, lat, ba, be, de, hd);
        n_run++; if (res !== 8'h00) begin n_fail++; $display("FAIL mul_zero: got %h expected 00", res); end
    endtask

    task automatic test_div();
        logic [7:0] res; logic flg, ba, be, de, hd; int lat;
        do_op4(2'b11, 4'b1101, 4'b0011, res, flg, lat, ba, be, de, hd);
        n_run++; if (res !== 8'h14) begin n_fail++; $display("FAIL div_result: got %h expected 14", res); end
        n_run++; if (flg !== 1'b0) begin n_fail++; $display("FAIL div_flag: got %b expected 0", flg); end
        n_run++; if (lat !== 4) begin n_fail++; $display("FAIL div_latency: got %0d expected 4", lat); end
        do_op4(2'b11, 4'b1010, 4'b0000, res, flg, lat, ba, be, de, hd);
        n_run++; if (res !== 8'hAF) begin n_fail++; $display("FAIL div_by_zero_result: got %h expected af", res); end
        n_run++; if (flg !== 1'b1) begin n_fail++; $display("FAIL div_by_zero_flag: got %b expected 1", flg); end
        n_run++; if (lat !== 4) begin n_fail++; $display("FAIL div_by_zero_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] res; logic flg, ba, be, de, hd, saw_done; int lat;
        @(negedge clk);
        if4.op = 2'b10; if4.a = 4'd7; if4.b = 4'd9; if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        n_run++; if (if4.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", if4.busy); end
        n_run++; if (if4.done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b expected 0", if4.done); end
        n_run++; if (if4.result !== 8'h00) begin n_fail++; $display("FAIL async_reset_result: got %h expected 00", if4.result); end
        n_run++; if (if4.flag !== 1'b0) begin n_fail++; $display("FAIL async_reset_flag: got %b expected 0", if4.flag); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (if4.done || if4.busy) saw_done = 1'b1;
        end
        n_run++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL aborted_op_activity: got %b expected 0", saw_done); end
        do_op4(2'b00, 4'b0001, 4'b0001, res, flg, lat, ba, be, de, hd);
        n_run++; if (res !== 8'h02) begin n_fail++; $display("FAIL post_reset_add: got %h expected 02", res); end
        n_run++; if (lat !== 1) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 1", lat); end
    endtask

    // start held high; inputs change every cycle; accepts only at k, k+L+2, ...
    task automatic test_back_to_back();
        int next_acc, done_at, l;
        logic [16:0] exp;
        logic exp_done, exp_busy;
        next_acc = 0;
        done_at = -1;
        exp = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if4.op = 2'(c % 4);
            if4.a = 4'((c * 5 + 3) % 16);
            if4.b = 4'((c * 7 + 1) % 16);
            if4.start = 1'b1;
            @(posedge clk); #1;
            if (c == next_acc) begin
                l = if4.op[1] ? 4 : 1;
                done_at = c + l;
                next_acc = c + l + 2;
                exp = model(4, if4.op, int'(if4.a), int'(if4.b));
            end
            exp_done = (c == done_at);
            exp_busy = (c <= done_at);
            n_run++; if (if4.done !== exp_done) begin
                n_fail++; $display("FAIL b2b_done@%0d: got %b expected %b", c, if4.done, exp_done);
            end
            n_run++; if (if4.busy !== exp_busy) begin
                n_fail++; $display("FAIL b2b_busy@%0d: got %b expected %b", c, if4.busy, exp_busy);
            end
            if (exp_done) begin
                n_run++; if ({if4.flag, if4.result} !== {exp[16], exp[7:0]}) begin
                    n_fail++; $display("FAIL b2b_result@%0d: got %b/%h expected %b/%h", c, if4.flag, if4.result, exp[16], exp[7:0]);
                end
            end
        end
        if4.start = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_exhaustive_w4();
        logic [7:0] res; logic flg, ba, be, de, hd; int lat, el;
        logic [16:0] exp;
        for (int o = 0; o < 4; o++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    do_op4(2'(o), 4'(x), 4'(y), res, flg, lat, ba, be, de, hd);
                    exp = model(4, 2'(o), x, y);
                    el = (o >= 2) ? 4 : 1;
                    n_run++; if ({flg, res} !== {exp[16], exp[7:0]} || lat !== el) begin
                        n_fail++;
                        $display("FAIL w4_op%0d_%0d_%0d: got %b/%h lat %0d expected %b/%h lat %0d",
                                 o, x, y, flg, res, lat, exp[16], exp[7:0], el);
                    end
                end
            end
        end
    endtask

    task automatic test_random_w8();
        logic [15:0] res; logic flg; int lat, el, x, y;
        logic [16:0] exp;
        for (int i = 0; i < 200; i++) begin
            x = int'($urandom_range(255, 0));
            y = (i % 10 == 0) ? 0 : int'($urandom_range(255, 0));
            do_op8(2'(i % 4), 8'(x), 8'(y), res, flg, lat);
            exp = model(8, 2'(i % 4), x, y);
            el = ((i % 4) >= 2) ? 8 : 1;
            n_run++; if ({flg, res} !== exp || lat !== el) begin
                n_fail++;
                $display("FAIL w8_op%0d_%0d_%0d: got %b/%h lat %0d expected %b/%h lat %0d",
                         i % 4, x, y, flg, res, lat, exp[16], exp[15:0], el);
            end
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        reset_n = 1'b0;
        if4.start = 1'b0; if4.op = '0; if4.a = '0; if4.b = '0;
        if8.start = 1'b0; if8.op = '0; if8.a = '0; if8.b = '0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_reset_mid_mul();
        test_back_to_back();
        test_exhaustive_w4();
        test_random_w8();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
